// File: rtl/line_buffer_scheduler_if.sv
// Bundles the line-buffer scheduler's control and status signals.
// Purpose : one bundle between the input logic / buffer / reader and the
//           scheduler. Clock and reset stay plain ports on the scheduler.
// Modports: master - the input logic side. It drives the I_* pulses and levels
//                    and observes the O_* block selects and status.
//           slave  - the scheduler. It samples I_* and drives O_*.
// Optional: LINE_SCHED_STATS_EN adds O_drop_count and O_max_fill.
interface line_buffer_scheduler_if #(
  parameter int BLOCK_COUNT = 2,
  parameter int MAX_HEIGHT  = 1080
);
  localparam int BLK_W  = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
  localparam int ROW_W  = $clog2(MAX_HEIGHT);
  localparam int FILL_W = $clog2(BLOCK_COUNT) + 1;

  logic              I_image_valid;
  logic              I_frame_start;
  logic              I_swap_trigger;
  logic              I_read_done;
  logic [BLK_W-1:0]  O_write_block;
  logic [BLK_W-1:0]  O_read_block;
  logic [ROW_W-1:0]  O_read_row;
  logic              O_read_valid;
  logic [FILL_W-1:0] O_fill;
  logic              O_line_dropped;
  logic              O_active;
`ifdef LINE_SCHED_STATS_EN
  logic [15:0]       O_drop_count;
  logic [FILL_W-1:0] O_max_fill;
`endif

  modport master (
    output I_image_valid, I_frame_start, I_swap_trigger, I_read_done,
    input  O_write_block, O_read_block, O_read_row, O_read_valid, O_fill,
           O_line_dropped, O_active
`ifdef LINE_SCHED_STATS_EN
    , input O_drop_count, O_max_fill
`endif
  );

  modport slave (
    input  I_image_valid, I_frame_start, I_swap_trigger, I_read_done,
    output O_write_block, O_read_block, O_read_row, O_read_valid, O_fill,
           O_line_dropped, O_active
`ifdef LINE_SCHED_STATS_EN
    , output O_drop_count, O_max_fill
`endif
  );
endinterface

// File: rtl/line_buffer_scheduler.sv
// Hands the BLOCK_COUNT line-buffer blocks between the HDMI input writer and
// the matrix output reader.
// Purpose : each completed input line is committed from the writer's block
//           into a FIFO of full blocks. Each full block carries the image row
//           it holds. When no free block exists, the line is dropped and the
//           writer refills the same block.
// Ports   : I_rgb_clk - clock for all logic
//           I_rst_n   - asynchronous, active-low reset
//           bus       - line_buffer_scheduler_if.slave with these signals:
//                       I_image_valid, I_frame_start, I_swap_trigger, I_read_done
//                       O_write_block, O_read_block, O_read_row, O_read_valid,
//                       O_fill, O_line_dropped, O_active
//                       (O_drop_count and O_max_fill with LINE_SCHED_STATS_EN)
// Optional: define LINE_SCHED_STATS_EN for the drop counter and the fill
//           high-water mark.
module line_buffer_scheduler #(
  parameter int BLOCK_COUNT = 2,
  parameter int MAX_HEIGHT  = 1080,
  parameter int BLK_W       = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
  input  logic                    I_rgb_clk,
  input  logic                    I_rst_n,
  line_buffer_scheduler_if.slave  bus
);
  localparam int ROW_W  = $clog2(MAX_HEIGHT);
  localparam int FILL_W = $clog2(BLOCK_COUNT) + 1;
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(BLOCK_COUNT - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BLOCK_COUNT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MAX_HEIGHT - 1);

  typedef enum logic [0:0] {WAIT_FRAME, RUN} state_t;

  // Explicit wrap so that block counts which are not a power of two work.
  function automatic logic [BLK_W-1:0] nxt_blk(input logic [BLK_W-1:0] p);
    return (p == LAST_BLK) ? '0 : p + BLK_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] sat_row(input logic [ROW_W-1:0] r);
    return (r == ROW_LAST) ? r : r + ROW_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   tags_q [BLOCK_COUNT];
  logic [ROW_W-1:0]   tags_d [BLOCK_COUNT];
  logic               drop_d, sw_ok, rd_ok;
  logic [ROW_W-1:0]   read_row_q;
  logic               read_valid_q, drop_q, active_q;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    fill_d  = fill_q;
    row_d   = row_q;
    tags_d  = tags_q;
    drop_d  = 1'b0;
    sw_ok   = 1'b0;
    rd_ok   = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (bus.I_frame_start && bus.I_image_valid) begin
          state_d = RUN;
          row_d   = '0;
        end
      end
      RUN: begin
        if (!bus.I_image_valid) begin
          // Abort: drop everything queued. The writer keeps its block.
          state_d = WAIT_FRAME;
          fill_d  = '0;
          rp_d    = wp_q;
        end else begin
          rd_ok = bus.I_read_done && (fill_q != '0);
          // When the queue is full, a swap is accepted only if a block is released in the same cycle.
          sw_ok  = bus.I_swap_trigger && ((fill_q < FILL_LAST) || rd_ok);
          drop_d = bus.I_swap_trigger && !sw_ok;
          if (sw_ok) begin
            tags_d[wp_q] = row_q;
            wp_d         = nxt_blk(wp_q);
          end
          if (rd_ok) rp_d = nxt_blk(rp_q);
          case ({sw_ok, rd_ok})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
          endcase
          if (bus.I_swap_trigger) row_d = sat_row(row_q);
          // A frame start takes priority, so a coincident swap leaves the counter at 0.
          if (bus.I_frame_start) row_d = '0;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // Register stage: all state and all outputs.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= WAIT_FRAME;
      wp_q         <= '0;
      rp_q         <= '0;
      fill_q       <= '0;
      row_q        <= '0;
      read_row_q   <= '0;
      read_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      active_q     <= 1'b0;
      for (int i = 0; i < BLOCK_COUNT; i++) tags_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      fill_q       <= fill_d;
      row_q        <= row_d;
      tags_q       <= tags_d;
      read_row_q   <= tags_d[rp_d];
      read_valid_q <= (fill_d != '0);
      drop_q       <= drop_d;
      active_q     <= (state_d == RUN);
    end
  end

  assign bus.O_write_block  = wp_q;
  assign bus.O_read_block   = rp_q;
  assign bus.O_read_row     = read_row_q;
  assign bus.O_read_valid   = read_valid_q;
  assign bus.O_fill         = fill_q;
  assign bus.O_line_dropped = drop_q;
  assign bus.O_active       = active_q;

`ifdef LINE_SCHED_STATS_EN
  logic [15:0]       drop_cnt_q;
  logic [FILL_W-1:0] max_fill_q;

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      drop_cnt_q <= '0;
      max_fill_q <= '0;
    end else begin
      if (bus.I_frame_start)                      drop_cnt_q <= '0;
      else if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (fill_d > max_fill_q) max_fill_q <= fill_d;
    end
  end

  assign bus.O_drop_count = drop_cnt_q;
  assign bus.O_max_fill   = max_fill_q;
`endif
endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed bench for line_buffer_scheduler. It drives two instances: one with
// two blocks and full HD height, and one with three blocks and height 8, so
// that pointer wrap and row saturation are reachable. For each step the
// expected output snapshot is queued when the inputs are driven. It is
// popped and compared one cycle later.
module tb_line_buffer_scheduler;
  typedef struct {
    int wb; int rb; int row; int rv; int fill; int drop; int act;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  line_buffer_scheduler_if #(.BLOCK_COUNT(2), .MAX_HEIGHT(1080)) if2 ();
  line_buffer_scheduler_if #(.BLOCK_COUNT(3), .MAX_HEIGHT(8))    if3 ();

  line_buffer_scheduler #(.BLOCK_COUNT(2), .MAX_HEIGHT(1080)) dut2 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .bus(if2.slave));
  line_buffer_scheduler #(.BLOCK_COUNT(3), .MAX_HEIGHT(8)) dut3 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .bus(if3.slave));

  function automatic exp_t mk(int wb, int rb, int row, int rv, int fill, int drop, int act);
    exp_t e;
    e.wb = wb; e.rb = rb; e.row = row; e.rv = rv; e.fill = fill; e.drop = drop; e.act = act;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp2(string tag);
    exp_t e;
    e = q2.pop_front();
    chk({tag, ".wb"},   32'(if2.O_write_block),  e.wb);
    chk({tag, ".rb"},   32'(if2.O_read_block),   e.rb);
    chk({tag, ".row"},  32'(if2.O_read_row),     e.row);
    chk({tag, ".rv"},   32'(if2.O_read_valid),   e.rv);
    chk({tag, ".fill"}, 32'(if2.O_fill),         e.fill);
    chk({tag, ".drop"}, 32'(if2.O_line_dropped), e.drop);
    chk({tag, ".act"},  32'(if2.O_active),       e.act);
  endtask

  task automatic cmp3(string tag);
    exp_t e;
    e = q3.pop_front();
    chk({tag, ".wb"},   32'(if3.O_write_block),  e.wb);
    chk({tag, ".rb"},   32'(if3.O_read_block),   e.rb);
    chk({tag, ".row"},  32'(if3.O_read_row),     e.row);
    chk({tag, ".rv"},   32'(if3.O_read_valid),   e.rv);
    chk({tag, ".fill"}, 32'(if3.O_fill),         e.fill);
    chk({tag, ".drop"}, 32'(if3.O_line_dropped), e.drop);
    chk({tag, ".act"},  32'(if3.O_active),       e.act);
  endtask

  // Drive one cycle of inputs, queue the expected result, then check it one cycle later.
  task automatic step2(string tag, bit sw, bit rd, bit fs, bit iv, exp_t e);
    if2.I_swap_trigger = sw; if2.I_read_done = rd;
    if2.I_frame_start  = fs; if2.I_image_valid = iv;
    q2.push_back(e);
    @(posedge clk); #1;
    cmp2(tag);
  endtask

  task automatic step3(string tag, bit sw, bit rd, bit fs, bit iv, exp_t e);
    if3.I_swap_trigger = sw; if3.I_read_done = rd;
    if3.I_frame_start  = fs; if3.I_image_valid = iv;
    q3.push_back(e);
    @(posedge clk); #1;
    cmp3(tag);
  endtask

  initial begin
    if2.I_swap_trigger = 1'b0; if2.I_read_done = 1'b0;
    if2.I_frame_start  = 1'b0; if2.I_image_valid = 1'b0;
    if3.I_swap_trigger = 1'b0; if3.I_read_done = 1'b0;
    if3.I_frame_start  = 1'b0; if3.I_image_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q2.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cmp2("reset2");
    q3.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cmp3("reset3");
    rst_n = 1'b1;

    // Startup, first commit and read.
    step2("pre_frame_swap", 1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    step2("frame_start",    0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));
    step2("commit0",        1, 0, 0, 1, mk(1, 0, 0, 1, 1, 0, 1));
    step2("read0",          0, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 1));
    // Overflow: a second swap into a full queue is dropped.
    step2("fs_again",       0, 0, 1, 1, mk(1, 1, 0, 0, 0, 0, 1));
    step2("ovf_sw1",        1, 0, 0, 1, mk(0, 1, 0, 1, 1, 0, 1));
    step2("ovf_drop",       1, 0, 0, 1, mk(0, 1, 0, 1, 1, 1, 1));
    step2("drop_pulse_end", 0, 0, 0, 1, mk(0, 1, 0, 1, 1, 0, 1));
    step2("swap_with_read", 1, 1, 0, 1, mk(1, 0, 2, 1, 1, 0, 1));
    step2("drain",          0, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 1));
    // A frame start that coincides with a swap: the old row is tagged and the counter restarts at 0.
    step2("fs_with_swap",   1, 0, 1, 1, mk(0, 1, 3, 1, 1, 0, 1));
    step2("row_restart",    1, 1, 0, 1, mk(1, 0, 0, 1, 1, 0, 1));
    step2("drain2",         0, 1, 0, 1, mk(1, 1, 3, 0, 0, 0, 1));
    step2("read_empty",     0, 1, 0, 1, mk(1, 1, 3, 0, 0, 0, 1));
    // Abort with a pending block.
    step2("pre_abort",      1, 0, 0, 1, mk(0, 1, 1, 1, 1, 0, 1));
    step2("abort",          0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step2("read_in_wait",   0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    step2("swap_in_wait",   1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    // Reset asserted mid-operation.
    step2("restart",        0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));
    step2("rs_sw",          1, 0, 0, 1, mk(1, 0, 0, 1, 1, 0, 1));
    step2("rs_sw_rd",       1, 1, 0, 1, mk(0, 1, 1, 1, 1, 0, 1));
    if2.I_swap_trigger = 1'b0; if2.I_read_done = 1'b0; if2.I_frame_start = 1'b0;
    rst_n = 1'b0;
    #2;
    q2.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cmp2("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step2("after_reset",    0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));

    // Five consecutive drops, then a frame start.
    step2("st_fs",          0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));
    step2("st_fill",        1, 0, 0, 1, mk(1, 0, 0, 1, 1, 0, 1));
    for (int k = 0; k < 5; k++)
      step2($sformatf("st_drop%0d", k), 1, 0, 0, 1, mk(1, 0, 0, 1, 1, 1, 1));
`ifdef LINE_SCHED_STATS_EN
    chk("drop_count5", 32'(if2.O_drop_count), 5);
    chk("max_fill2",   32'(if2.O_max_fill),   1);
`endif
    step2("st_fs_clr",      0, 0, 1, 1, mk(1, 0, 0, 1, 1, 0, 1));
`ifdef LINE_SCHED_STATS_EN
    chk("drop_count_clr", 32'(if2.O_drop_count), 0);
    chk("max_fill_keep",  32'(if2.O_max_fill),   1);
`endif
    if2.I_frame_start = 1'b0;

    // Three blocks: pointer wrap over seven swap/read pairs.
    step3("w_fs", 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) begin
      step3($sformatf("w_sw%0d", i), 1, 0, 0, 1, mk((i + 1) % 3, i % 3, i, 1, 1, 0, 1));
      step3($sformatf("w_rd%0d", i), 0, 1, 0, 1,
            mk((i + 1) % 3, (i + 1) % 3, (i >= 2) ? i - 2 : 0, 0, 0, 0, 1));
    end
    // The row counter has reached MAX_HEIGHT-1 and must hold there.
    step3("sat_sw1",   1, 0, 0, 1, mk(2, 1, 7, 1, 1, 0, 1));
    step3("sat_sw2",   1, 0, 0, 1, mk(0, 1, 7, 1, 2, 0, 1));
    step3("full_drop", 1, 0, 0, 1, mk(0, 1, 7, 1, 2, 1, 1));
    step3("sat_rd",    0, 1, 0, 1, mk(0, 2, 7, 1, 1, 0, 1));
    step3("both",      1, 1, 0, 1, mk(1, 0, 7, 1, 1, 0, 1));
`ifdef LINE_SCHED_STATS_EN
    chk("max_fill3", 32'(if3.O_max_fill), 2);
`endif
    if3.I_swap_trigger = 1'b0; if3.I_read_done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/line_buffer_scheduler.md
Name: line_buffer_scheduler

Overview:
- Sequences ownership of the BLOCK_COUNT line-buffer blocks shared between the HDMI input writer and the matrix output reader.
- Each completed input line is committed from the writer's block into a FIFO of full blocks. The reader consumes these blocks in order.
- The block drives the write and read block selects of the dual-port buffer, tags each full block with its image row, and drops lines when no free block exists.
- It sits between the input logic (swap trigger, frame sync, image valid) and the buffer and reader.

Parameters:
- BLOCK_COUNT, 2, number of line-buffer blocks; legal values are 2 to 8.
- MAX_HEIGHT, 1080, maximum image rows; row fields are $clog2(MAX_HEIGHT) bits wide.
- BLK_W, $clog2(BLOCK_COUNT) (minimum 1), width of the block index.

Ports:
- I_rgb_clk  in  1  single clock for all logic.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_image_valid  in  1  image geometry valid; a low level aborts operation.
- I_frame_start  in  1  single-cycle pulse at the start of a frame.
- I_swap_trigger  in  1  single-cycle pulse; the current write block holds one complete line.
- I_read_done  in  1  single-cycle pulse; the reader has finished the block at O_read_block.
- O_write_block  out  BLK_W  block currently being filled by the writer.
- O_read_block  out  BLK_W  oldest full block.
- O_read_row  out  $clog2(MAX_HEIGHT)  image row stored in O_read_block.
- O_read_valid  out  1  at least one full block is pending.
- O_fill  out  $clog2(BLOCK_COUNT)+1  number of full blocks pending.
- O_line_dropped  out  1  single-cycle pulse; a line was discarded.
- O_active  out  1  state machine is in RUN.

Behaviour:
- All outputs are registered. Reset values:
  - O_write_block = 0, O_read_block = 0, O_read_row = 0.
  - O_read_valid = 0, O_fill = 0, O_line_dropped = 0, O_active = 0.
  - Internal: wp = 0, rp = 0, row counter = 0, all row tags = 0.
  - State = WAIT_FRAME.
- State machine:
  - WAIT_FRAME -> RUN on I_frame_start while I_image_valid = 1. The row counter is set to 0.
  - RUN -> WAIT_FRAME whenever I_image_valid = 0. This flushes the queue: fill = 0, rp = wp, O_read_valid = 0 on the next cycle.
  - In WAIT_FRAME, I_swap_trigger and I_read_done are ignored.
- Write pointer wp = O_write_block and read pointer rp = O_read_block. Both wrap from BLOCK_COUNT-1 to 0; non-power-of-two counts use explicit compare, not natural overflow.
- Accepted swap, in RUN, when I_swap_trigger = 1 and either fill < BLOCK_COUNT-1 or (fill = BLOCK_COUNT-1 and I_read_done = 1 with fill > 0):
  - tag[wp] <= row counter, wp advances, fill increments.
- Dropped swap, in RUN, when I_swap_trigger = 1, fill = BLOCK_COUNT-1 and I_read_done = 0:
  - wp is held, so the writer overwrites the same block.
  - O_line_dropped pulses for one cycle.
- Every swap in RUN, accepted or dropped, increments the row counter. The row counter saturates at MAX_HEIGHT-1.
- Read done, in RUN, when I_read_done = 1 and fill > 0: rp advances and fill decrements.
  - I_read_done while fill = 0 is ignored.
- Simultaneous accepted swap and read done: both pointers advance and fill is unchanged.
- I_frame_start in RUN resets the row counter to 0 and leaves the queue intact. If it coincides with a swap, the swap is tagged with the old row and the counter becomes 0, not 1.
- O_read_valid = (fill != 0). O_read_row = tag[rp]. Both are valid in the cycle after a pointer or fill update; latency is 1 cycle from the input pulse.
- Invariant: wp is never equal to rp while fill > 0. At most BLOCK_COUNT-1 blocks are full.
- Reset asserted mid-operation returns immediately to the reset values; an in-flight line is lost.

Optional Feature:
- Macro: LINE_SCHED_STATS_EN.
- With the macro defined, two extra outputs are added:
  - O_drop_count (16 bits, saturating at 0xFFFF), incremented on each O_line_dropped and cleared on I_frame_start.
  - O_max_fill ($clog2(BLOCK_COUNT)+1 bits), the high-water mark of fill since reset.
- Without the macro, neither port nor its counters exist, and all other behaviour is identical.

Test Plan:
- Startup: reset, then I_swap_trigger before any I_frame_start -> fill stays 0, O_active = 0. Then frame_start with image_valid = 1 -> O_active = 1 the next cycle.
- Basic commit, BLOCK_COUNT = 2: frame_start, then one swap -> O_write_block = 1, O_read_block = 0, O_read_valid = 1, O_read_row = 0. read_done -> O_read_valid = 0, O_read_block = 1.
- Overflow, BLOCK_COUNT = 2: two swaps with no read_done -> second swap gives O_line_dropped = 1 for 1 cycle, O_write_block stays 1, fill = 1. A third swap coinciding with read_done is accepted and its block is tagged row 2.
- Wrap, BLOCK_COUNT = 3: 7 swap/read_done pairs -> O_write_block sequence 1, 2, 0, 1, 2, 0, 1. O_read_row matches rows 0 to 6.
- Abort: fill = 1, then image_valid = 0 for 1 cycle -> O_read_valid = 0, O_active = 0 the next cycle. A later read_done has no effect.
- Stats (LINE_SCHED_STATS_EN): 5 drops -> O_drop_count = 5, O_max_fill = BLOCK_COUNT-1. frame_start -> O_drop_count = 0, O_max_fill unchanged.
